seq_mul8: RTL

- Sequential shift-add unsigned multiplier that sits directly upstream of the team's 8-bit carry-lookahead adder.
- Each iteration it drives the adder's operand and carry-in inputs and consumes its sum and carry-out. The adder is an external combinational instance, wired at the parent level.
- Accepts one WIDTH x WIDTH operand pair on a start pulse, iterates WIDTH cycles, and returns a 2*WIDTH-bit product with a done pulse.
- Used as the multiply stage of the arithmetic lab datapath.

---
 rtl/seq_mul8.sv | 111 +++++++++++
 1 files changed

// File: rtl/seq_mul8.sv
// Sequential shift-add unsigned multiplier driving an external WIDTH-bit adder.
// One iteration per cycle; the product is loaded into p on the RUN->DONE transition.
module seq_mul8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    add_a   = hi_q;
    add_b   = '0;
    add_cin = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Sum is always taken; with lo[0]=0 the adder simply passes hi through.
        add_b = lo_q[0] ? m_q : '0;
        hi_d  = {add_cout, add_s[WIDTH-1:1]};
        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          p_d     = {hi_d, lo_d};
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
